// File: rtl/score_pkg.sv
// score_pkg: shared FSM states, score limit and saturating pending arithmetic
package score_pkg;
   typedef enum logic [1:0] {IDLE, PULSE_UP, PULSE_DN, GAP} state_t;
   localparam logic [6:0] SCORE_MAX = 7'd99;
   typedef logic signed [3:0] pend_t;
   function automatic pend_t pend_sat(input logic signed [4:0] v, input logic [2:0] lim);
      logic signed [4:0] m;
      m = $signed({2'b00, lim});
      return (v > m) ? pend_t'(m) : (v < -m) ? pend_t'(-m) : pend_t'(v);
   endfunction
endpackage

// File: rtl/score_event_pulser_rise_detect.sv
// rise_detect: registered single-cycle pulse on each 0->1 transition of a level
module rise_detect (
   input  logic clk,
   input  logic resetN,
   input  logic in,
   output logic pulse
);
   logic prev;
   logic armed;
   // armed suppresses the first cycle after reset so a level already high is not an edge
   always_ff @(posedge clk)
      if (!resetN) begin
         prev  <= 1'b0;
         armed <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev  <= in;
         armed <= 1'b1;
         pulse <= armed & in & ~prev;
      end
endmodule

// File: rtl/score_event_pulser.sv
// score_event_pulser: turns add/sub level edges into spaced up/down pulses with a clamped shadow score
module score_event_pulser
   import score_pkg::*;
#(
   parameter int PULSE_LEN = 2,
   parameter int GAP_LEN   = 2,
   parameter int PEND_MAX  = 7
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       addPoint,
   input  logic       subPoint,
   output logic       up,
   output logic       down,
   output logic [6:0] score,
   output logic       busy
);
   localparam logic [3:0] P_LAST = 4'(PULSE_LEN - 1);
   localparam logic [3:0] G_LAST = 4'(GAP_LEN - 1);
   localparam logic [2:0] LIM    = 3'(PEND_MAX);

   logic              add_e;
   logic              sub_e;
   state_t            state;
   state_t            state_n;
   logic [3:0]        cnt;
   logic [3:0]        cnt_n;
   logic [6:0]        score_n;
   pend_t             pend;
   pend_t             pend_n;
   logic signed [4:0] delta;
   logic signed [4:0] eff;

   rise_detect u_add (.clk(clk), .resetN(resetN), .in(addPoint), .pulse(add_e));
   rise_detect u_sub (.clk(clk), .resetN(resetN), .in(subPoint), .pulse(sub_e));

   assign delta = (add_e == sub_e) ? 5'sd0 : add_e ? 5'sd1 : -5'sd1;
   assign eff   = $signed({pend[3], pend}) + delta;

   // next state: fresh edges join pending before IDLE decides, so a lone edge pulses two cycles later
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      score_n = score;
      pend_n  = pend_sat(eff, LIM);
      case (state)
         IDLE:
            if (eff > 5'sd0) begin
               if (score == SCORE_MAX) pend_n = '0;
               else begin
                  state_n = PULSE_UP;
                  cnt_n   = '0;
                  score_n = score + 7'd1;
                  pend_n  = pend_sat(eff - 5'sd1, LIM);
               end
            end else if (eff < 5'sd0) begin
               if (score == 7'd0) pend_n = '0;
               else begin
                  state_n = PULSE_DN;
                  cnt_n   = '0;
                  score_n = score - 7'd1;
                  pend_n  = pend_sat(eff + 5'sd1, LIM);
               end
            end
         PULSE_UP, PULSE_DN: begin
            state_n = (cnt == P_LAST) ? GAP : state;
            cnt_n   = (cnt == P_LAST) ? 4'd0 : cnt + 4'd1;
         end
         GAP: begin
            state_n = (cnt == G_LAST) ? IDLE : GAP;
            cnt_n   = (cnt == G_LAST) ? 4'd0 : cnt + 4'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   // state and all outputs are registered from the next-state values
   always_ff @(posedge clk)
      if (!resetN) begin
         state <= IDLE;
         cnt   <= '0;
         score <= '0;
         pend  <= '0;
         up    <= 1'b0;
         down  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         score <= score_n;
         pend  <= pend_n;
         up    <= (state_n == PULSE_UP);
         down  <= (state_n == PULSE_DN);
         busy  <= (pend_n != 4'sd0) | (state_n != IDLE);
      end
endmodule
